spi_slave_top: RTL and testbench
================================

// Module: spi_slave_top
// PURPOSE
//  SPI slave byte transceiver, mode 0 (CPOL=0, CPHA=0), MSB first, SCK driven by external master.
//  Pads are oversampled in the single system clock domain; no logic is clocked by SCK.
//  Each completed byte is presented on d_recieved with a one-cycle DRDY strobe.
//  Sits between the GPIO pads and user logic; e.g. a byte sets a clock-divider compare value.
// PARAMETERS
//  BYTE_W  8  bits per SPI word (rx and tx width), >= 2
// PORTS
//  clk         in   1       system clock (PLL output, e.g. 100 MHz); all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  sck_pad     in   1       SPI clock from master, idle low, async to clk
//  csn_pad     in   1       SPI chip select, active low, async to clk
//  mosi_pad    in   1       master-out data, async to clk
//  miso_pad    out  1       slave-out data, always driven (no tristate)
//  DRDY        out  1       one-clk strobe: new word valid on d_recieved
//  d_recieved  out  BYTE_W  last complete received word, MSB = first bit on wire
//  d_to_send   in   BYTE_W  word to transmit, sampled at load points (below)
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-high (rst).
//  - Reset: d_recieved=0, DRDY=0, miso_pad=0, all shift regs/counters 0, synchronizers to idle (sck=0, csn=1).
//  - sck/csn/mosi each pass a 2-FF synchronizer; edges are detected by comparing sync stage
//    with its previous value. Rise/fall strobes are 1 clk wide.
//  - Requirement on master: SCK high and low phases >= 3 clk periods each; CSN low-to-first-SCK-rise >= 4 clk.
//  - CSN high (synced): bit counter held at 0, miso_pad=0, DRDY=0, rx shift ignores SCK.
//  - CSN fall: tx_shift <= d_to_send; miso_pad = tx_shift[BYTE_W-1]; bit counter=0.
//  - SCK rise while CSN low: rx_shift <= {rx_shift[BYTE_W-2:0], mosi_sync}; counter++.
//    Sampled mosi is the synced value in the same cycle as the rise strobe.
//  - On BYTE_W-th rise: d_recieved <= completed word (including the bit just sampled);
//    DRDY=1 the following cycle only; counter wraps to 0; set reload flag.
//  - SCK fall while CSN low: if reload flag, tx_shift <= d_to_send and clear flag;
//    else tx_shift <= tx_shift << 1. miso_pad always = tx_shift[BYTE_W-1] while CSN low.
//  - Multi-word: consecutive words within one CSN low are supported with no gap; each yields a DRDY.
//  - CSN rise mid-word: partial word discarded, no DRDY, d_recieved unchanged, reload flag cleared.
//  - CSN rise and BYTE_W-th SCK rise in same cycle: the word completes (DRDY issued), then idle.
//  - d_recieved holds its value until the next complete word or reset.
//  - rst asserted mid-transfer: everything returns to reset values immediately; no DRDY.
// TESTING
//  1 Reset: rst=1 -> miso_pad=0, DRDY=0, d_recieved=8'h00; release, CSN high -> all stay idle.
//  2 Single byte: d_to_send=8'hA5, master sends 8'h3C (SCK=clk/8) -> master reads 8'hA5,
//    d_recieved=8'h3C, exactly one DRDY pulse of 1 clk after the 8th SCK rise.
//  3 Two bytes in one CSN frame: send 8'h01 then 8'hFE, d_to_send changed 8'h11->8'h22 after
//    first DRDY -> d_recieved 8'h01 then 8'hFE, two DRDY pulses, master reads 8'h11, 8'h22.
//  4 Abort: CSN raised after 5 bits -> no DRDY, d_recieved keeps previous 8'hFE; next full
//    frame sending 8'h80 -> d_recieved=8'h80.
//  5 Reset mid-byte: rst pulsed after 4 bits -> outputs reset, no DRDY; following frame
//    8'h5A received correctly.
//  6 Minimum timing: SCK phases = 3 clk, CSN-to-SCK = 4 clk, random bytes x100 -> all match.

Source files
------------

// File: rtl/spi_slave_top.sv
// ---------------------------------------------------------------------------
// spi_slave_top
//   SPI slave byte transceiver in mode 0 (CPOL=0, CPHA=0), MSB first.
//   The SCK/CSN/MOSI pads are oversampled in the clk domain; nothing is
//   clocked by SCK. Each completed word appears on d_recieved together with
//   a one-clk DRDY strobe. Words can be streamed back to back inside one
//   CSN-low frame.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   sck_pad     in   SPI clock from master (idle low), async to clk
//   csn_pad     in   SPI chip select (active low), async to clk
//   mosi_pad    in   master-out data, async to clk
//   miso_pad    out  slave-out data, always driven, 0 while deselected
//   DRDY        out  one-clk strobe, new word on d_recieved
//   d_recieved  out  last complete received word (MSB = first bit on wire)
//   d_to_send   in   word to transmit, sampled at CSN fall and after each
//                    completed word (on the following SCK fall)
//
// Frame FSM
//   state     | meaning
//   ST_IDLE   | CSN high: counter held at 0, SCK ignored, MISO low
//   ST_ACTIVE | CSN low: shifting on synced SCK edges
// ---------------------------------------------------------------------------
module spi_slave_top #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck_pad,
    input  logic              csn_pad,
    input  logic              mosi_pad,
    output logic              miso_pad,
    output logic              DRDY,
    output logic [BYTE_W-1:0] d_recieved,
    input  logic [BYTE_W-1:0] d_to_send
);

    localparam int              CNT_W    = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // synchronizers plus one history stage each for edge detection
    logic r_sck_s1, r_sck_s2, r_sck_d;
    logic r_csn_s1, r_csn_s2, r_csn_d;
    logic r_mosi_s1, r_mosi_s2;

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0] r_rx_shift;
    logic [BYTE_W-1:0] r_tx_shift;
    logic [BYTE_W-1:0] r_d_recieved;
    logic              r_drdy;
    logic              r_reload;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_csn_fall;
    logic w_csn_rise;
    logic w_rx_en;
    logic w_tx_step;
    logic w_tx_load_start;
    logic w_word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_csn_s1  <= 1'b1;
            r_csn_s2  <= 1'b1;
            r_csn_d   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sck_s1  <= sck_pad;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_csn_s1  <= csn_pad;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
            r_mosi_s1 <= mosi_pad;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sck_rise =  r_sck_s2 & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s2 &  r_sck_d;
    assign w_csn_fall = ~r_csn_s2 &  r_csn_d;
    assign w_csn_rise =  r_csn_s2 & ~r_csn_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The state only leaves ACTIVE one cycle after the CSN rise strobe, so a
    // final SCK rise arriving in the same cycle as the CSN rise still
    // completes its word.
    always_comb begin
        w_state_nxt     = r_state;
        w_rx_en         = 1'b0;
        w_tx_step       = 1'b0;
        w_tx_load_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt     = ST_ACTIVE;
                    w_tx_load_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_rx_en   = w_sck_rise;
                w_tx_step = w_sck_fall & ~r_csn_s2;
                if (w_csn_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_word_done = w_rx_en && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (r_csn_s2 || w_tx_load_start) begin
            // deselect (including the CSN rise cycle) drops any partial word
            r_bit_cnt <= '0;
        end else if (w_rx_en) begin
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift   <= '0;
            r_d_recieved <= '0;
            r_drdy       <= 1'b0;
        end else begin
            r_drdy <= w_word_done;
            if (w_rx_en) begin
                r_rx_shift <= {r_rx_shift[BYTE_W-2:0], r_mosi_s2};
            end
            if (w_word_done) begin
                r_d_recieved <= {r_rx_shift[BYTE_W-2:0], r_mosi_s2};
            end
        end
    end

    // After a completed word the next SCK fall loads a fresh d_to_send
    // instead of shifting, so the master sees the new MSB on its next rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
        end else if (w_tx_load_start) begin
            r_tx_shift <= d_to_send;
        end else if (w_tx_step) begin
            if (r_reload) begin
                r_tx_shift <= d_to_send;
            end else begin
                r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload <= 1'b0;
        end else if (w_csn_rise || w_tx_load_start) begin
            r_reload <= 1'b0;
        end else if (w_word_done) begin
            r_reload <= 1'b1;
        end else if (w_tx_step) begin
            r_reload <= 1'b0;
        end
    end

    assign miso_pad   = (r_state == ST_ACTIVE) && !r_csn_s2 && r_tx_shift[BYTE_W-1];
    assign DRDY       = r_drdy;
    assign d_recieved = r_d_recieved;

endmodule

// File: tb/tb_spi_slave_top.sv
module tb_spi_slave_top;

    logic       clk;
    logic       rst;
    logic       sck_pad;
    logic       csn_pad;
    logic       mosi_pad;
    logic       miso_pad;
    logic       DRDY;
    logic [7:0] d_recieved;
    logic [7:0] d_to_send;

    int n_checks = 0;
    int n_errors = 0;

    int         drdy_pulses = 0;
    int         drdy_high   = 0;
    logic       drdy_prev   = 1'b0;
    logic [7:0] drdy_data   = 8'h00;

    spi_slave_top #(.BYTE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sck_pad    (sck_pad),
        .csn_pad    (csn_pad),
        .mosi_pad   (mosi_pad),
        .miso_pad   (miso_pad),
        .DRDY       (DRDY),
        .d_recieved (d_recieved),
        .d_to_send  (d_to_send)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRDY monitor: counts pulses and high cycles, latches data on each pulse
    always @(negedge clk) begin
        if (DRDY === 1'b1) begin
            drdy_high = drdy_high + 1;
            if (drdy_prev !== 1'b1) begin
                drdy_pulses = drdy_pulses + 1;
                drdy_data   = d_recieved;
            end
        end
        drdy_prev = DRDY;
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        int         nbits;
        logic [7:0] exp_rd;
        logic [7:0] exp_drec;
        int         exp_drdy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input int setup);
        csn_pad = 1'b0;
        wait_clk(setup);
    endtask

    task automatic frame_end(input int ph);
        sck_pad = 1'b0;
        wait_clk(ph);
        csn_pad = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int ph,
                             output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck_pad  = 1'b0;
            mosi_pad = b[7-i];
            wait_clk(ph);
            sck_pad = 1'b1;
            rd      = {rd[6:0], miso_pad};
            wait_clk(ph);
        end
    endtask

    initial begin
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic [7:0] tx_r;
        logic [7:0] mo_r;
        int         p0;

        vecs[0] = '{tx: 8'hC6, mosi: 8'h9B, nbits: 5, exp_rd: 8'h18, exp_drec: 8'hFE, exp_drdy: 0};
        vecs[1] = '{tx: 8'h3D, mosi: 8'h80, nbits: 8, exp_rd: 8'h3D, exp_drec: 8'h80, exp_drdy: 1};
        vecs[2] = '{tx: 8'hA5, mosi: 8'h3C, nbits: 8, exp_rd: 8'hA5, exp_drec: 8'h3C, exp_drdy: 1};
        vecs[3] = '{tx: 8'hFF, mosi: 8'h00, nbits: 8, exp_rd: 8'hFF, exp_drec: 8'h00, exp_drdy: 1};
        vecs[4] = '{tx: 8'h00, mosi: 8'hFF, nbits: 8, exp_rd: 8'h00, exp_drec: 8'hFF, exp_drdy: 1};
        vecs[5] = '{tx: 8'h69, mosi: 8'h96, nbits: 8, exp_rd: 8'h69, exp_drec: 8'h96, exp_drdy: 1};
        vecs[6] = '{tx: 8'h01, mosi: 8'h33, nbits: 2, exp_rd: 8'h00, exp_drec: 8'h96, exp_drdy: 0};
        vecs[7] = '{tx: 8'h81, mosi: 8'h7E, nbits: 7, exp_rd: 8'h40, exp_drec: 8'h96, exp_drdy: 0};

        rst       = 1'b1;
        sck_pad   = 1'b0;
        csn_pad   = 1'b1;
        mosi_pad  = 1'b0;
        d_to_send = 8'h00;

        // reset state
        wait_clk(3);
        chk("reset_miso", miso_pad, 1'b0);
        chk("reset_drdy", DRDY, 1'b0);
        chk("reset_drec", d_recieved, 8'h00);
        rst = 1'b0;

        // CSN high: SCK/MOSI activity must be ignored
        for (int i = 0; i < 10; i++) begin
            mosi_pad = 1'b1;
            sck_pad  = 1'b1;
            wait_clk(4);
            chk("idle_miso", miso_pad, 1'b0);
            sck_pad = 1'b0;
            wait_clk(4);
        end
        mosi_pad = 1'b0;
        chk("idle_drdy_cnt", drdy_pulses, 0);
        chk("idle_drec", d_recieved, 8'h00);

        // two words in one frame, d_to_send changed after the first DRDY
        d_to_send = 8'h11;
        frame_start(2);
        send_bits(8'h01, 8, 4, rd0);
        chk("two_b1_drdy_cnt", drdy_pulses, 1);
        chk("two_b1_data", drdy_data, 8'h01);
        d_to_send = 8'h22;
        send_bits(8'hFE, 8, 4, rd1);
        frame_end(4);
        chk("two_b1_read", rd0, 8'h11);
        chk("two_b2_read", rd1, 8'h22);
        chk("two_b2_data", drdy_data, 8'hFE);
        chk("two_drec", d_recieved, 8'hFE);
        chk("two_drdy_cnt", drdy_pulses, 2);

        // table: single frames, full words and aborts (SCK = clk/8)
        for (int v = 0; v < 8; v++) begin
            p0        = drdy_pulses;
            d_to_send = vecs[v].tx;
            frame_start(2);
            send_bits(vecs[v].mosi, vecs[v].nbits, 4, rd0);
            frame_end(4);
            chk($sformatf("vec%0d_read", v), rd0, vecs[v].exp_rd);
            chk($sformatf("vec%0d_drec", v), d_recieved, vecs[v].exp_drec);
            chk($sformatf("vec%0d_drdy", v), drdy_pulses - p0, vecs[v].exp_drdy);
            chk($sformatf("vec%0d_miso_idle", v), miso_pad, 1'b0);
        end
        chk("drdy_width", drdy_high, drdy_pulses);

        // CSN rise coincident with the last SCK rise: word still completes
        p0        = drdy_pulses;
        d_to_send = 8'hB4;
        frame_start(2);
        send_bits(8'h4B, 7, 4, rd0);
        sck_pad  = 1'b0;
        mosi_pad = 1'b1;
        wait_clk(4);
        sck_pad = 1'b1;
        csn_pad = 1'b1;
        wait_clk(8);
        sck_pad = 1'b0;
        wait_clk(4);
        chk("cs_edge_drec", d_recieved, 8'h4B);
        chk("cs_edge_drdy", drdy_pulses - p0, 1);
        chk("cs_edge_read", rd0, 8'h5A);

        // reset in the middle of a word
        p0        = drdy_pulses;
        d_to_send = 8'hFF;
        frame_start(2);
        send_bits(8'hAB, 4, 4, rd0);
        rst = 1'b1;
        #1;
        chk("midrst_miso", miso_pad, 1'b0);
        chk("midrst_drdy", DRDY, 1'b0);
        chk("midrst_drec", d_recieved, 8'h00);
        sck_pad  = 1'b0;
        csn_pad  = 1'b1;
        mosi_pad = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(8);
        chk("midrst_drdy_cnt", drdy_pulses - p0, 0);
        chk("midrst_drec_after", d_recieved, 8'h00);

        p0        = drdy_pulses;
        d_to_send = 8'hC3;
        frame_start(2);
        send_bits(8'h5A, 8, 4, rd0);
        frame_end(4);
        chk("postrst_drec", d_recieved, 8'h5A);
        chk("postrst_read", rd0, 8'hC3);
        chk("postrst_drdy", drdy_pulses - p0, 1);

        // minimum timing: 3-clk SCK phases, 4 clk CSN-to-first-rise
        for (int n = 0; n < 100; n++) begin
            tx_r      = 8'($urandom_range(0, 255));
            mo_r      = 8'($urandom_range(0, 255));
            p0        = drdy_pulses;
            d_to_send = tx_r;
            frame_start(1);
            send_bits(mo_r, 8, 3, rd0);
            frame_end(3);
            chk($sformatf("rnd%0d_drec", n), d_recieved, mo_r);
            chk($sformatf("rnd%0d_read", n), rd0, tx_r);
            chk($sformatf("rnd%0d_drdy", n), drdy_pulses - p0, 1);
        end
        chk("final_drdy_width", drdy_high, drdy_pulses);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
